state_polytomsg__seq: RTL and testbench
=======================================

STATE_POLYTOMSG__SEQ -- requirements
Module: State_Polytomsg__Seq

Interface
REQ-001 SHALL have parameter KYBER_N, default 256, the number of coefficients per polynomial.
REQ-002 SHALL have parameter i_Coeffs_Width, default 12, the coefficient width.
REQ-003 SHALL have parameter Msg_Byte_Width, default 8, the message byte width.
REQ-004 SHALL have clk  input  1  single clock; every register updates on the rising edge.
REQ-005 SHALL have reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have start  input  1  one-cycle request to convert one polynomial.
REQ-007 SHALL have busy  output  1  high from the cycle after an accepted start until done.
REQ-008 SHALL have done  output  1  one-cycle pulse when all 32 bytes are written.
REQ-009 SHALL have poly_rd_en, poly_addr  output  1, 8  coefficient RAM read strobe and address; read data is valid one cycle later.
REQ-010 SHALL have poly_rdata  input  12  coefficient RAM read data.
REQ-011 SHALL have dc_enable, dc_coeffs  output  1, 12  per-coefficient start and operand for the downstream bit-compute stage.
REQ-012 SHALL have dc_done, dc_msg  input  1, 1  result strobe and message bit from that stage.
REQ-013 SHALL have msg_wr_en, msg_addr, msg_wdata  output  1, 5, 8  message byte write port.

Function
REQ-014 SHALL use FSM states IDLE, READ, WAIT_RD, CAL, WAIT_DC, NEXT and DONE.
REQ-015 SHALL make registered outputs.
REQ-016 SHALL, in IDLE with start=1, clear idx (8 bits) and byte_reg (8 bits) and go to READ.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 SHALL, in READ, drive poly_rd_en=1 for one cycle with poly_addr=idx, then go to WAIT_RD.
REQ-019 SHALL, in WAIT_RD, capture poly_rdata into dc_coeffs and go to CAL.
REQ-020 SHALL, in CAL, drive dc_enable=1 for exactly one cycle with dc_coeffs stable, then go to WAIT_DC.
REQ-021 SHALL hold dc_coeffs stable until the next CAL.
REQ-022 SHALL remain in WAIT_DC with no timeout until dc_done=1.
REQ-023 SHALL ignore dc_done in any state other than WAIT_DC.
REQ-024 SHALL, on dc_done in WAIT_DC, set byte_reg[idx[2:0]]=dc_msg, packing LSB-first (coefficient 8k+j goes to byte k, bit j).
REQ-025 SHALL, on that same edge when idx[2:0]=7, register msg_wdata={dc_msg,byte_reg[6:0]}, msg_addr=idx[7:3] and msg_wr_en=1.
REQ-026 SHALL assert msg_wr_en for exactly one cycle per byte, giving exactly 32 writes at addresses 0..31 in ascending order.
REQ-027 SHALL, in NEXT, deassert msg_wr_en and clear byte_reg if idx[2:0]=7.
REQ-028 SHALL, in NEXT, go to DONE if idx=KYBER_N-1; otherwise it SHALL increment idx and go to READ.
REQ-029 SHALL keep idx from wrapping during a conversion.
REQ-030 SHALL, in DONE, pulse done=1 for one cycle, drop busy and return to IDLE; start is accepted again from IDLE on the following cycle.
REQ-031 SHALL take per-coefficient latency of 5 cycles plus the dc_done wait cycles in WAIT_DC.
REQ-032 SHALL produce results that do not depend on the dc_done latency.

Reset
REQ-033 SHALL, when reset=1 on any edge, including mid-conversion, force state IDLE.
REQ-034 SHALL, on that reset, set idx=0, byte_reg=0 and all outputs 0 (busy, done, poly_rd_en, poly_addr, dc_enable, dc_coeffs, msg_wr_en, msg_addr, msg_wdata).
REQ-035 SHALL have reset take priority over start and dc_done.
REQ-036 SHALL, after reset, not complete an aborted conversion and not generate done for it.

Verification
REQ-037 SHALL cover: all 256 coefficients = 0, bit-compute model (2c+1664)/3329 bit 0 -> 32 writes of 0x00, addresses 0..31, one done pulse.
REQ-038 SHALL cover: all coefficients = 1665 -> 32 writes of 0xFF.
REQ-039 SHALL cover: even-index coefficients = 832, odd-index = 1665 -> every byte 0xAA; with coefficient 0 = 1665 and the rest 0 -> byte 0 = 0x01, others 0x00.
REQ-040 SHALL cover: dc_done latency randomized 1..40 cycles, plus a spurious dc_done in READ -> output identical to the fixed-latency run, with no extra bit packed.
REQ-041 SHALL cover: start re-pulsed while busy -> ignored, exactly 32 writes and one done.
REQ-042 SHALL cover: reset asserted right after the write to msg_addr=3 -> all outputs 0 next cycle, no further writes, no done; a new start then gives the full 32 writes from address 0.

Source files
------------

// File: rtl/state_polytomsg__seq.sv
// Polynomial-to-message packer: walks KYBER_N coefficients through an external
// bit-compute stage and packs the returned bits LSB-first into 32 message bytes.
// Index arithmetic assumes the default sizes (8-bit idx, 8-bit message bytes).
module state_polytomsg__seq #(
  parameter int unsigned KYBER_N        = 256,
  parameter int unsigned i_Coeffs_Width = 12,
  parameter int unsigned Msg_Byte_Width = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      poly_rd_en,
  output logic [7:0]                poly_addr,
  input  logic [i_Coeffs_Width-1:0] poly_rdata,
  output logic                      dc_enable,
  output logic [i_Coeffs_Width-1:0] dc_coeffs,
  input  logic                      dc_done,
  input  logic                      dc_msg,
  output logic                      msg_wr_en,
  output logic [4:0]                msg_addr,
  output logic [Msg_Byte_Width-1:0] msg_wdata
);

  localparam logic [7:0] LastIdx = 8'(KYBER_N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWaitRd,
    StCal,
    StWaitDc,
    StNext,
    StDone
  } state_t;

  state_t                    state_q;
  logic [7:0]                idx_q;
  logic [Msg_Byte_Width-1:0] byte_reg_q;

  // Single-process FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      byte_reg_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      poly_rd_en <= 1'b0;
      poly_addr  <= '0;
      dc_enable  <= 1'b0;
      dc_coeffs  <= '0;
      msg_wr_en  <= 1'b0;
      msg_addr   <= '0;
      msg_wdata  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            idx_q      <= '0;
            byte_reg_q <= '0;
            busy       <= 1'b1;
            state_q    <= StRead;
          end
        end
        StRead: begin
          poly_rd_en <= 1'b1;
          poly_addr  <= idx_q;
          state_q    <= StWaitRd;
        end
        StWaitRd: begin
          poly_rd_en <= 1'b0;
          dc_coeffs  <= poly_rdata;
          state_q    <= StCal;
        end
        StCal: begin
          dc_enable <= 1'b1;
          state_q   <= StWaitDc;
        end
        StWaitDc: begin
          dc_enable <= 1'b0;
          if (dc_done) begin
            byte_reg_q[idx_q[2:0]] <= dc_msg;
            // Last bit of a byte: the fresh bit bypasses byte_reg_q into the write data.
            if (idx_q[2:0] == 3'd7) begin
              msg_wdata <= {dc_msg, byte_reg_q[Msg_Byte_Width-2:0]};
              msg_addr  <= idx_q[7:3];
              msg_wr_en <= 1'b1;
            end
            state_q <= StNext;
          end
        end
        StNext: begin
          msg_wr_en <= 1'b0;
          if (idx_q[2:0] == 3'd7) begin
            byte_reg_q <= '0;
          end
          if (idx_q == LastIdx) begin
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= StRead;
          end
        end
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_state_polytomsg__seq.sv
// Self-checking bench: coefficient RAM and bit-compute stage models, expected
// bytes derived from the packing rule applied directly to the coefficient array.
module tb_state_polytomsg__seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        poly_rd_en;
  logic [7:0]  poly_addr;
  logic [11:0] poly_rdata;
  logic        dc_enable;
  logic [11:0] dc_coeffs;
  logic        dc_done;
  logic        dc_msg;
  logic        msg_wr_en;
  logic [4:0]  msg_addr;
  logic [7:0]  msg_wdata;

  int errors = 0;
  int checks = 0;

  logic [11:0] mem [256];
  logic [4:0]  wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int          done_cnt;

  // Downstream stage behaviour knobs
  bit rand_lat;
  int fixed_lat;
  bit spurious;

  state_polytomsg__seq #(
    .KYBER_N       (256),
    .i_Coeffs_Width(12),
    .Msg_Byte_Width(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .poly_rd_en(poly_rd_en),
    .poly_addr (poly_addr),
    .poly_rdata(poly_rdata),
    .dc_enable (dc_enable),
    .dc_coeffs (dc_coeffs),
    .dc_done   (dc_done),
    .dc_msg    (dc_msg),
    .msg_wr_en (msg_wr_en),
    .msg_addr  (msg_addr),
    .msg_wdata (msg_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered address, so data follows the read strobe by one cycle.
  assign poly_rdata = mem[poly_addr];

  function automatic logic msg_bit(input int c);
    return 1'(((2 * c + 1664) / 3329) % 2);
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] b = 8'h00;
    for (int j = 0; j < 8; j++) b[j] = msg_bit(int'(mem[8 * k + j]));
    return b;
  endfunction

  // Bit-compute stage model, with optional spurious strobe during the next READ.
  initial begin
    int          lat;
    logic [11:0] c;
    dc_done = 1'b0;
    dc_msg  = 1'b0;
    forever begin
      @(negedge clk);
      if (dc_enable === 1'b1 && reset === 1'b0) begin
        c   = dc_coeffs;
        lat = rand_lat ? int'($urandom_range(1, 40)) : fixed_lat;
        repeat (lat) @(negedge clk);
        dc_done = 1'b1;
        dc_msg  = msg_bit(int'(c));
        @(negedge clk);
        dc_done = 1'b0;
        dc_msg  = 1'b0;
        if (spurious) begin
          @(negedge clk);
          dc_done = 1'b1;
          dc_msg  = 1'b1;
          @(negedge clk);
          dc_done = 1'b0;
          dc_msg  = 1'b0;
        end
      end
    end
  end

  // Write and done monitor
  always @(negedge clk) begin
    if (msg_wr_en === 1'b1) begin
      wr_addr_q.push_back(msg_addr);
      wr_data_q.push_back(msg_wdata);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_and_check(input string name, input bit repulse);
    int n;
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
      start = (repulse && (n == 10 || n == 100 || n == 500)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    checks++;
    if (n >= 30000) begin
      errors++;
      $display("FAIL %s done_timeout: got no done within %0d cycles", name, n);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
    end
    checks++;
    if (wr_addr_q.size() !== 32) begin
      errors++;
      $display("FAIL %s write_count: got %0d want 32", name, wr_addr_q.size());
    end
    for (int k = 0; k < 32 && k < wr_addr_q.size(); k++) begin
      checks++;
      if ({wr_addr_q[k], wr_data_q[k]} !== {5'(k), exp_byte(k)}) begin
        errors++;
        $display("FAIL %s write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                 name, k, wr_addr_q[k], wr_data_q[k], k, exp_byte(k));
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_done: got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, poly_rd_en, poly_addr, dc_enable, dc_coeffs, msg_wr_en, msg_addr,
         msg_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b addr=%h en=%b coef=%h wr=%b ma=%h wd=%h want all 0",
               busy, done, poly_rd_en, poly_addr, dc_enable, dc_coeffs, msg_wr_en, msg_addr,
               msg_wdata);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_patterns();
    rand_lat  = 1'b0;
    fixed_lat = 1;
    spurious  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 12'd0;
    run_and_check("zeros", 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = 12'd1665;
    run_and_check("ones", 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 0) ? 12'd832 : 12'd1665;
    run_and_check("alt_aa", 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = 12'd0;
    mem[0] = 12'd1665;
    run_and_check("single_bit", 1'b0);
  endtask

  task automatic test_random_latency();
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(0, 3328));
    rand_lat  = 1'b0;
    fixed_lat = 3;
    spurious  = 1'b0;
    run_and_check("rand_fixed_lat", 1'b0);
    rand_lat = 1'b1;
    spurious = 1'b1;
    run_and_check("rand_var_lat_spurious", 1'b0);
    rand_lat = 1'b0;
    spurious = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    fixed_lat = 1;
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(0, 3328));
    run_and_check("restart_while_busy", 1'b1);
    clear_obs();
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_addr_q.size() !== 0) begin
      errors++;
      $display("FAIL idle_after_repulse: got busy=%b writes=%0d want busy=0 writes=0",
               busy, wr_addr_q.size());
    end
    n = 0;
  endtask

  task automatic test_abort();
    int n;
    fixed_lat = 2;
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(0, 3328));
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(msg_wr_en === 1'b1 && msg_addr === 5'd3) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL abort_wait: got no write to address 3 within %0d cycles", n);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, poly_rd_en, poly_addr, dc_enable, dc_coeffs, msg_wr_en, msg_addr,
         msg_wdata} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b rd=%b addr=%h en=%b coef=%h wr=%b ma=%h wd=%h want all 0",
               busy, done, poly_rd_en, poly_addr, dc_enable, dc_coeffs, msg_wr_en, msg_addr,
               msg_wdata);
    end
    clear_obs();
    repeat (150) @(negedge clk);
    checks++;
    if (wr_addr_q.size() !== 0 || done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got writes=%0d dones=%0d want 0 and 0",
               wr_addr_q.size(), done_cnt);
    end
    run_and_check("after_abort", 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    rand_lat  = 1'b0;
    fixed_lat = 1;
    spurious  = 1'b0;
    done_cnt  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 12'd0;
    test_reset();
    test_patterns();
    test_random_latency();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
